// File: rtl/core1_feeder_if.sv
// Producer stream plus the core1 pulse-and-hold issue/complete signals.
// The slave side is the feeder; the master side is its environment.
interface core1_feeder_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] core_data_in;
    logic        core_valid_in;
    logic        core_valid_out;

    modport slave (
        input  s_data, s_valid, core_valid_out,
        output s_ready, core_data_in, core_valid_in
    );
    modport master (
        output s_data, s_valid, core_valid_out,
        input  s_ready, core_data_in, core_valid_in
    );
endinterface

// File: rtl/core1_feeder.sv
// Buffers producer words in a FIFO and issues them one at a time to core1,
// waiting (with a timeout guard) for each completion pulse before the next issue.
module core1_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    core1_feeder_if.slave          bus,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [15:0]            done_count,
    output logic                   err,
    input  logic                   err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [AW:0]   FULL   = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] timer;
    logic [31:0]   hold_q;
    logic          issue_q;
    logic          push, pop, cmpl, tmo;

    // s_ready comes only from registered occupancy, so a pop never frees a slot in the same cycle
    assign bus.s_ready       = (fifo_count != FULL);
    assign bus.core_data_in  = hold_q;
    assign bus.core_valid_in = issue_q;

    assign push = bus.s_valid && bus.s_ready;
    assign cmpl = (state == WAIT) && bus.core_valid_out;
    assign tmo  = (state == WAIT) && !bus.core_valid_out && (timer == T_LAST);
    assign pop  = (fifo_count != '0) && ((state == IDLE) || cmpl);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.s_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            timer      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            hold_q     <= '0;
            issue_q    <= 1'b0;
            done_count <= '0;
            err        <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            // The issue pulse is registered so it lines up with the hold register load
            issue_q <= pop;

            case (state)
                IDLE:  if (pop) state <= ISSUE;
                ISSUE: state <= HOLD;
                HOLD: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (cmpl) begin
                        done_count <= done_count + 16'd1;
                        state      <= pop ? ISSUE : IDLE;
                    end else if (tmo) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (tmo)          err <= 1'b1;
            else if (err_clr) err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_core1_feeder.sv
// Directed bench for core1_feeder with a fixed-latency core1 OR-combine model attached.
module tb_core1_feeder;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        err_clr = 1'b0;
    logic [2:0]  fifo_count;
    logic [15:0] done_count;
    logic        err;

    logic core_en = 1'b1;
    logic spur = 1'b0;
    logic p1, p2, p3;
    logic [15:0] ld;
    int cyc = 0;
    int n_chk = 0;
    int n_err = 0;
    logic [31:0] iss_q[$];
    int          iss_c[$];
    logic [31:0] res_q[$];

    core1_feeder_if bus ();

    core1_feeder #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .fifo_count (fifo_count),
        .done_count (done_count),
        .err        (err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    // core1 model: samples valid_in, loads data next cycle, completes in the third cycle after issue
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
            p3 <= 1'b0;
            ld <= '0;
        end else begin
            p1 <= bus.core_valid_in;
            p2 <= p1;
            p3 <= p2;
            if (p1) ld <= bus.core_data_in[31:16] | bus.core_data_in[15:0];
            if (p3 && core_en) res_q.push_back({16'h0, ld});
        end
    end
    assign bus.core_valid_out = (p3 && core_en) || spur;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.core_valid_in) begin
            iss_q.push_back(bus.core_data_in);
            iss_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.s_data  = w;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int target);
        for (int i = 0; i < 200 && int'(done_count) != target; i++) tick();
        chk(tag, 32'(done_count), 32'(target));
    endtask

    function automatic logic [31:0] pop_res();
        if (res_q.size() == 0) return 32'hDEAD_BEEF;
        return res_q.pop_front();
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(bus.s_ready), 1);
        chk({tag, "_vin"}, 32'(bus.core_valid_in), 0);
        chk({tag, "_din"}, bus.core_data_in, 0);
        chk({tag, "_cnt"}, 32'(fifo_count), 0);
        chk({tag, "_done"}, 32'(done_count), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    logic [31:0] w [1:5];
    logic [31:0] r [1:5];

    initial begin
        int base, d, n, ni;
        w[1] = 32'h1234_0001; r[1] = 32'h0000_1235;
        w[2] = 32'hA5A5_5A5A; r[2] = 32'h0000_FFFF;
        w[3] = 32'h0000_FFFF; r[3] = 32'h0000_FFFF;
        w[4] = 32'h8000_0001; r[4] = 32'h0000_8001;
        w[5] = 32'h0F0F_0F00; r[5] = 32'h0000_0F0F;
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk_reset_vals("rst");

        // single word: push-to-issue latency, one-cycle pulse, held data, completion
        bus.s_data  = 32'h00F0_000F;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        chk("t1_cnt_push", 32'(fifo_count), 1);
        chk("t1_vin_idle", 32'(bus.core_valid_in), 0);
        tick();
        chk("t1_vin_issue", 32'(bus.core_valid_in), 1);
        chk("t1_din_issue", bus.core_data_in, 32'h00F0_000F);
        chk("t1_cnt_pop", 32'(fifo_count), 0);
        tick();
        chk("t1_vin_hold", 32'(bus.core_valid_in), 0);
        chk("t1_din_hold", bus.core_data_in, 32'h00F0_000F);
        wait_done("t1_done", 1);
        chk("t1_dout", pop_res(), 32'h0000_00FF);
        repeat (4) tick();
        chk("t1_idle_vin", 32'(bus.core_valid_in), 0);
        chk("t1_niss", 32'(iss_q.size()), 1);

        // fill FIFO while core is busy, hold a 5th word against backpressure
        core_en = 1'b0;
        base = iss_q.size();
        d = int'(done_count);
        push_word(32'h1111_0000);
        repeat (3) tick();
        for (int i = 1; i <= 4; i++) begin
            bus.s_data  = w[i];
            bus.s_valid = 1'b1;
            tick();
        end
        chk("t2_full_cnt", 32'(fifo_count), 4);
        chk("t2_full_rdy", 32'(bus.s_ready), 0);
        bus.s_data = w[5];
        repeat (2) tick();
        chk("t2_stall_rdy", 32'(bus.s_ready), 0);
        chk("t2_stall_cnt", 32'(fifo_count), 4);
        spur = 1'b1;
        tick();
        spur    = 1'b0;
        core_en = 1'b1;
        chk("t2_nobypass_cnt", 32'(fifo_count), 3);
        chk("t2_pop_rdy", 32'(bus.s_ready), 1);
        chk("t2_w0_done", 32'(done_count), 32'(d + 1));
        tick();
        bus.s_valid = 1'b0;
        chk("t2_w5_cnt", 32'(fifo_count), 4);
        wait_done("t2_done", d + 6);
        chk("t2_cnt_end", 32'(fifo_count), 0);
        chk("t2_niss", 32'(iss_q.size()), 32'(base + 6));
        for (int i = 1; i <= 5; i++) begin
            chk($sformatf("t2_order%0d", i), iss_q[base + i], w[i]);
            chk($sformatf("t2_dout%0d", i), pop_res(), r[i]);
            if (i > 1) chk($sformatf("t2_gap%0d", i), 32'(iss_c[base + i] - iss_c[base + i - 1]), 4);
        end

        // timeout: core silent, err_clr held so the set must win
        repeat (3) tick();
        core_en = 1'b0;
        err_clr = 1'b1;
        d = int'(done_count);
        bus.s_data  = 32'hDEAD_0000;
        bus.s_valid = 1'b1;
        tick();
        bus.s_data = 32'h0001_0002;
        tick();
        bus.s_valid = 1'b0;
        chk("t3_issue", 32'(bus.core_valid_in), 1);
        n = 0;
        while (err !== 1'b1 && n <= 40) begin
            tick();
            n++;
        end
        chk("t3_tmo_lat", 32'(n), 18);
        chk("t3_done_keep", 32'(done_count), 32'(d));
        core_en = 1'b1;
        tick();
        chk("t3_err_clr", 32'(err), 0);
        err_clr = 1'b0;
        wait_done("t3_next_done", d + 1);
        chk("t3_next_word", iss_q[iss_q.size() - 1], 32'h0001_0002);
        chk("t3_next_dout", pop_res(), 32'h0000_0003);
        chk("t3_nores", 32'(res_q.size()), 0);

        // spurious completion pulses in IDLE and HOLD
        repeat (3) tick();
        d  = int'(done_count);
        ni = iss_q.size();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        repeat (3) tick();
        chk("t4_idle_done", 32'(done_count), 32'(d));
        chk("t4_idle_niss", 32'(iss_q.size()), 32'(ni));
        push_word(32'h0001_0000);
        tick();
        chk("t4_issue", 32'(bus.core_valid_in), 1);
        tick();
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("t4_hold_done", 32'(done_count), 32'(d));
        wait_done("t4_done", d + 1);
        repeat (6) tick();
        chk("t4_done_keep", 32'(done_count), 32'(d + 1));
        chk("t4_dout", pop_res(), 32'h0000_0001);

        // asynchronous reset during HOLD with two words queued
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hAAAA_0001;
        tick();
        bus.s_data = 32'hBBBB_0002;
        tick();
        bus.s_data = 32'hCCCC_0003;
        tick();
        bus.s_valid = 1'b0;
        chk("t5_hold_cnt", 32'(fifo_count), 2);
        chk("t5_hold_din", bus.core_data_in, 32'hAAAA_0001);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t5_async");
        tick();
        tick();
        reset_n = 1'b1;
        ni = iss_q.size();
        repeat (10) tick();
        chk("t5_no_issue", 32'(iss_q.size()), 32'(ni));
        chk("t5_cnt", 32'(fifo_count), 0);
        push_word(32'h0000_0007);
        wait_done("t5_new_done", 1);
        chk("t5_new_word", iss_q[iss_q.size() - 1], 32'h0000_0007);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/core1_feeder.md
# core1_feeder

Upstream feeder for the `core1` OR-combine stage. It buffers 32-bit operand words from a valid/ready producer in a small FIFO. It issues them to `core1` one at a time using that stage's pulse-and-hold protocol: `valid_in` pulses for one cycle, and `data_in` stays stable through the following cycle. After each issue it waits for `core1`'s `valid_out` completion pulse, with a timeout guard, before issuing the next word.

## Interface
- `DEPTH`, 4: FIFO entries; power of 2, ≥ 2.
- `TIMEOUT`, 16: cycles spent in WAIT before an issue is abandoned; ≥ 4.
- `clk` in 1: clock, all logic on the rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `s_data` in 32: producer word (upper half is operand A, lower half is operand B).
- `s_valid` in 1: producer word valid.
- `s_ready` out 1: FIFO can accept; equals !full, registered-state derived.
- `core_data_in` out 32: to `core1` `data_in`; driven from the hold register.
- `core_valid_in` out 1: to `core1` `valid_in`; one-cycle issue pulse.
- `core_valid_out` in 1: from `core1` `valid_out`; completion pulse.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `done_count` out 16: completions received; wraps at 0xFFFF→0.
- `err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err`.

## Operation
- FIFO:
  - Push when `s_valid && s_ready`.
  - Pop only on entry to ISSUE.
  - Push and pop in the same cycle leave the count unchanged.
  - When full, `s_ready`=0 even if a pop occurs that cycle (no bypass).
  - Pointers wrap modulo DEPTH.
- Hold register:
  - Loaded with the FIFO head on the pop edge.
  - Otherwise unchanged; `core_data_in` = hold register at all times.
- FSM states IDLE, ISSUE, HOLD, WAIT:
  - IDLE: if `fifo_count`≠0, go to ISSUE and pop; else stay.
  - ISSUE: `core_valid_in`=1; next state HOLD.
  - HOLD: `core_valid_in`=0; data held for `core1`'s LOAD sample; timer cleared; next state WAIT.
  - WAIT: timer increments each cycle.
    - If `core_valid_out`=1: `done_count`+1. Then go to ISSUE with a pop if the FIFO is non-empty, else to IDLE.
    - Else if timer = TIMEOUT-1: set `err`, go to IDLE, word dropped, `done_count` not incremented.
- `core_valid_in` is high only in ISSUE, so it is never asserted while `core1` is busy.
- A `core_valid_out` pulse outside WAIT is ignored: no count change, no state change.
- `err`:
  - Set wins over `err_clr` in the same cycle.
  - `err_clr` alone clears it on the next edge.
  - `err` does not block operation.

## Timing
- Reset values:
  - `s_ready`=1, `core_valid_in`=0, `core_data_in`=0, `fifo_count`=0, `done_count`=0, `err`=0.
  - State IDLE, timer 0, FIFO pointers 0.
- Reset asserted mid-operation: all of the above take effect immediately (asynchronous); FIFO contents are discarded.
- Latency, push to issue with the feeder idle: word pushed at edge t → ISSUE (`core_valid_in`=1) in cycle t+2. The IDLE decision happens in cycle t+1.
- Per word:
  - `core1` returns `valid_out` in the third cycle after ISSUE: ISSUE at c, HOLD c+1, WAIT c+2, pulse seen in c+3.
  - Next ISSUE at c+4. Sustained throughput is 1 word / 4 cycles.
- `core_data_in` is stable from the ISSUE cycle until the next ISSUE cycle.
- `fifo_count` updates on the edge after the push/pop.
- `done_count` updates on the edge ending the WAIT cycle that sees the pulse.

## Test plan
- Reset, then push 0x00F0000F once:
  - `core_valid_in` pulses 1 cycle.
  - `core_data_in`=0x00F0000F for ≥2 cycles.
  - With a `core1` model attached, `core_valid_out` pulses and its `data_out`=0x000000FF.
  - `done_count`=1, state returns to IDLE.
- Push 4 words back-to-back (DEPTH=4):
  - All accepted, `s_ready` low once 4 are buffered with no issue yet.
  - Issues spaced exactly 4 cycles apart.
  - `done_count`=4, `fifo_count`=0.
- Fill the FIFO while the core is busy; hold `s_valid` with a 5th word:
  - `s_ready`=0 until the edge after a pop.
  - 5th word accepted then, with no loss or duplication (check order).
- Core model never responds:
  - `err`=1 exactly TIMEOUT cycles after entry to WAIT.
  - Next word issued normally; `done_count` unchanged for the dropped word.
  - `err_clr` → `err`=0.
- Spurious `core_valid_out` in IDLE and HOLD → `done_count` and state unchanged.
- Assert `reset_n` low during HOLD with 2 words queued:
  - Outputs at reset values immediately.
  - No further `core_valid_in` after release until new pushes arrive.
